line_buf_array: RTL and testbench
=================================

# line_buf_array

Multi-line video buffer that delays a raster pixel stream by 1..NUM_LINES whole lines. Each accepted pixel produces a registered vertical column: the current pixel plus the same-column pixel from each of the previous NUM_LINES lines. It adds per-tap validity for top-border handling and a runtime line length latched at frame start. It sits between the pixel input and the window/median stages and generalises the single fixed-latency line delay.

## Interface
- DATA_WIDTH, 8: pixel width in bits.
- NUM_LINES, 2: number of stored lines (taps); column height = NUM_LINES+1. Legal range 1..8.
- MAX_WIDTH, 8192: maximum line length; RAM depth per line.
- CW, $clog2(MAX_WIDTH)+1: width of line_len (derived, not overridden).

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- line_len  in  CW  pixels per line; sampled only on an accepted pixel with in_sof=1.
- in_valid  in  1  pixel qualifier; no backpressure, every valid pixel is accepted.
- in_sof  in  1  first pixel of frame; meaningful only with in_valid.
- data_in  in  DATA_WIDTH  pixel.
- out_valid  out  1  column valid.
- out_col  out  (NUM_LINES+1)*DATA_WIDTH  slice k = pixel from k lines ago; k=0 is the current pixel.
- out_tap_ok  out  NUM_LINES+1  bit k=1 when slice k belongs to the current frame; bit 0 is always 1 when out_valid.
- out_eol  out  1  column is the last pixel of its line.
- cfg_err  out  1  sticky: latched line_len <2 or >MAX_WIDTH. Cleared by rst or by a legal sof.

## Operation
- States: IDLE, FILL, RUN.
  - IDLE after reset. Pixels without in_sof are dropped, with no output and no RAM write.
  - An accepted in_sof pixel moves to FILL from any state: col=0, row=0, len latched.
  - FILL -> RUN when row reaches NUM_LINES.
  - RUN holds until the next sof or reset.
- Counters:
  - col increments per accepted pixel and wraps at len-1, then row increments.
  - row saturates at NUM_LINES; it serves only tap validity.
- Storage:
  - NUM_LINES RAMs of MAX_WIDTH x DATA_WIDTH, read-first, synchronous read at address col on every accepted pixel.
  - Writes occur in the following cycle (valid_d) at col_d, independent of in_valid that cycle. RAM0 is written with data_d; RAM k is written with RAM k-1's read data. This cascades lines through the array.
- Column:
  - out_col = {RAM(N-1) rd, ..., RAM0 rd, data_d}.
  - out_tap_ok[k] = (row_d >= k).
- Mid-frame sof: counters restart and tap validity restarts from row 0. Stale RAM contents are presented but flagged invalid through out_tap_ok.
- Illegal len:
  - cfg_err=1.
  - Counters wrap at MAX_WIDTH-1 when len > MAX_WIDTH.
  - They wrap at 1 when len < 2.
  - Column data is unspecified but out_valid timing is still honoured.

## Timing
- Latency is exactly 1 cycle from an accepted pixel to its column. out_valid = in_valid registered (gated by state).
- Gaps in in_valid are allowed anywhere. Output is emitted only on valid_d, and RAM contents are unaffected by gaps.
- Back-to-back pixels: the write at col_d and the read at col never collide because len >= 2.
- Reset values: out_valid=0, out_eol=0, out_tap_ok=0, out_col=0, cfg_err=0, state=IDLE, col=0, row=0. RAM contents are not reset.
- Reset mid-line: the next cycle shows out_valid=0. Any pending write from valid_d in the reset cycle is suppressed.
- A sof on the same cycle as the last pixel of a line: sof wins. That pixel is col 0, row 0.

## Structure
- Package line_buf_pkg holds:
  - state enum lb_state_t {IDLE, FILL, RUN};
  - the NUM_LINES legal-range check;
  - a packed column type helper.
- Sub-module line_ram: one simple dual-port read-first RAM (parameters DATA_WIDTH, DEPTH), instantiated NUM_LINES times via generate.
- Top level holds the counters, FSM, the valid_d/col_d/data_d pipeline and output registers.

## Test plan
- Basic, NUM_LINES=2, len=4: sof then 12 pixels with values 0..11, continuous.
  - Row 2, col 1 column = {9,5,1}, tap_ok=111.
  - Row 0 columns have tap_ok=001.
  - out_eol on pixels 3, 7 and 11.
- Gaps: the same stream with in_valid toggled 1,0,1,0.
  - Column values are identical to continuous mode.
  - out_valid follows in_valid by 1 cycle.
- Pre-sof drop: 5 valid pixels without sof, then sof.
  - No out_valid before the sof pixel's column.
  - First column tap_ok=001.
- Mid-frame sof: sof at row 1, col 2 with len=4.
  - That column has tap_ok=001.
  - Row counting restarts and len is re-latched.
- cfg_err: sof with len=1.
  - cfg_err=1 the next cycle.
  - A later sof with len=8 clears it.
- Reset mid-line: assert rst for 1 cycle during row 1.
  - Next cycle: out_valid=0, state IDLE.
  - Pixels are dropped until the next sof.

Source files
------------

// File: rtl/line_buf_pkg.sv
`default_nettype none
// ============================================================================
// line_buf_pkg: shared types and helpers for the multi-line video buffer
// Revision: 1.0
// ============================================================================
package line_buf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } lb_state_t;

  localparam int unsigned LB_MIN_LINES = 1;
  localparam int unsigned LB_MAX_LINES = 8;

  function automatic bit lb_num_lines_ok(input int unsigned n);
    return (n >= LB_MIN_LINES) && (n <= LB_MAX_LINES);
  endfunction

  // Packed width of one vertical column: current pixel plus nl stored lines.
  function automatic int unsigned lb_col_width(input int unsigned dw, input int unsigned nl);
    return (nl + 1) * dw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/line_ram.sv
`default_nettype none
// ============================================================================
// line_ram: simple dual-port, read-first RAM holding one video line
// Revision: 1.0
// ============================================================================
module line_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8192,
  localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Read and write in one process so a same-address access returns old data.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/line_buf_array.sv
`default_nettype none
// ============================================================================
// line_buf_array: delays a raster stream by 1..NUM_LINES lines, one column out
// Revision: 1.0
// ============================================================================
module line_buf_array
  import line_buf_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_LINES  = 2,
  parameter int MAX_WIDTH  = 8192,
  localparam int CW        = $clog2(MAX_WIDTH) + 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [CW-1:0]                       line_len,
  input  logic                                in_valid,
  input  logic                                in_sof,
  input  logic [DATA_WIDTH-1:0]               data_in,
  output logic                                out_valid,
  output logic [(NUM_LINES+1)*DATA_WIDTH-1:0] out_col,
  output logic [NUM_LINES:0]                  out_tap_ok,
  output logic                                out_eol,
  output logic                                cfg_err
);

  localparam int AW    = $clog2(MAX_WIDTH);
  localparam int RW    = $clog2(NUM_LINES + 1);
  localparam int COL_W = lb_col_width(DATA_WIDTH, NUM_LINES);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_FILL = FILL;
  localparam logic [1:0] ST_RUN  = RUN;

  localparam logic [AW-1:0] MAX_LIM = AW'(MAX_WIDTH - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(NUM_LINES);

  generate
    if (!lb_num_lines_ok(NUM_LINES)) begin : g_bad_num_lines
      $error("line_buf_array: NUM_LINES must be in 1..8");
    end
  endgenerate

  function automatic logic len_bad(input logic [CW-1:0] len);
    return (len < CW'(2)) || (len > CW'(MAX_WIDTH));
  endfunction

  // Last column index of a line; illegal lengths clamp to 1 or MAX_WIDTH-1.
  function automatic logic [AW-1:0] wrap_limit(input logic [CW-1:0] len);
    if (len > CW'(MAX_WIDTH)) begin
      return MAX_LIM;
    end else if (len < CW'(2)) begin
      return AW'(1);
    end
    return AW'(len - CW'(1));
  endfunction

  logic [1:0]            state_q, state_d;
  logic [AW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic [AW-1:0]         lim_q, lim_d;
  logic                  cfg_err_q, cfg_err_d;

  // _p1 registers describe the pixel accepted in the previous cycle.
  logic                  vld_p1_q, vld_p1_d;
  logic [AW-1:0]         col_p1_q, col_p1_d;
  logic [RW-1:0]         row_p1_q, row_p1_d;
  logic [DATA_WIDTH-1:0] data_p1_q, data_p1_d;
  logic                  eol_p1_q, eol_p1_d;

  logic                  acc;
  logic [AW-1:0]         col_cur;
  logic [RW-1:0]         row_cur;
  logic [AW-1:0]         lim_cur;
  logic                  eol_cur;

  always_comb begin
    acc     = in_valid && (in_sof || (state_q != ST_IDLE));
    col_cur = in_sof ? '0 : col_q;
    row_cur = in_sof ? '0 : row_q;
    lim_cur = in_sof ? wrap_limit(line_len) : lim_q;
    eol_cur = (col_cur == lim_cur);

    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    lim_d     = lim_q;
    cfg_err_d = cfg_err_q;
    vld_p1_d  = acc;
    col_p1_d  = col_p1_q;
    row_p1_d  = row_p1_q;
    data_p1_d = data_p1_q;
    eol_p1_d  = eol_p1_q;

    if (acc) begin
      lim_d = lim_cur;
      if (eol_cur) begin
        col_d = '0;
        row_d = (row_cur == ROW_MAX) ? row_cur : row_cur + RW'(1);
      end else begin
        col_d = col_cur + AW'(1);
        row_d = row_cur;
      end
      state_d = (row_d == ROW_MAX) ? ST_RUN : ST_FILL;
      if (in_sof) begin
        cfg_err_d = len_bad(line_len);
      end
      col_p1_d  = col_cur;
      row_p1_d  = row_cur;
      data_p1_d = data_in;
      eol_p1_d  = eol_cur;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      col_q     <= '0;
      row_q     <= '0;
      lim_q     <= '0;
      cfg_err_q <= 1'b0;
      vld_p1_q  <= 1'b0;
      col_p1_q  <= '0;
      row_p1_q  <= '0;
      data_p1_q <= '0;
      eol_p1_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      lim_q     <= lim_d;
      cfg_err_q <= cfg_err_d;
      vld_p1_q  <= vld_p1_d;
      col_p1_q  <= col_p1_d;
      row_p1_q  <= row_p1_d;
      data_p1_q <= data_p1_d;
      eol_p1_q  <= eol_p1_d;
    end
  end

  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_rd [NUM_LINES];
  logic [DATA_WIDTH-1:0] ram_wd [NUM_LINES];

  assign ram_we = vld_p1_q && !rst;

  // Each RAM is fed by its predecessor's read data, shifting lines down the stack.
  generate
    for (genvar k = 0; k < NUM_LINES; k++) begin : g_ram
      if (k == 0) begin : g_first
        assign ram_wd[k] = data_p1_q;
      end else begin : g_cascade
        assign ram_wd[k] = ram_rd[k-1];
      end

      line_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MAX_WIDTH)
      ) u_line_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (col_p1_q),
        .wr_data (ram_wd[k]),
        .rd_en   (acc),
        .rd_addr (col_cur),
        .rd_data (ram_rd[k])
      );
    end
  endgenerate

  logic [COL_W-1:0] col_w;
  logic [NUM_LINES:0] tap_w;

  always_comb begin
    col_w = '0;
    tap_w = '0;
    if (vld_p1_q) begin
      col_w[DATA_WIDTH-1:0] = data_p1_q;
      for (int k = 0; k < NUM_LINES; k++) begin
        col_w[(k+1)*DATA_WIDTH +: DATA_WIDTH] = ram_rd[k];
      end
      for (int k = 0; k <= NUM_LINES; k++) begin
        tap_w[k] = (row_p1_q >= RW'(k));
      end
    end
  end

  assign out_valid  = vld_p1_q;
  assign out_col    = col_w;
  assign out_tap_ok = tap_w;
  assign out_eol    = vld_p1_q && eol_p1_q;
  assign cfg_err    = cfg_err_q;

endmodule
`default_nettype wire

// File: tb/tb_line_buf_array.sv
`default_nettype none
// ============================================================================
// tb_line_buf_array: scoreboard bench for line_buf_array (NUM_LINES=2)
// Revision: 1.0
// ============================================================================
module tb_line_buf_array;

  localparam int DW   = 8;
  localparam int NL   = 2;
  localparam int MW   = 8192;
  localparam int CW   = $clog2(MW) + 1;
  localparam int COLW = (NL + 1) * DW;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [CW-1:0]   line_len = '0;
  logic            in_valid = 1'b0;
  logic            in_sof = 1'b0;
  logic [DW-1:0]   data_in = '0;
  logic            out_valid;
  logic [COLW-1:0] out_col;
  logic [NL:0]     out_tap_ok;
  logic            out_eol;
  logic            cfg_err;

  line_buf_array #(
    .DATA_WIDTH (DW),
    .NUM_LINES  (NL),
    .MAX_WIDTH  (MW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .line_len   (line_len),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .data_in    (data_in),
    .out_valid  (out_valid),
    .out_col    (out_col),
    .out_tap_ok (out_tap_ok),
    .out_eol    (out_eol),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [COLW-1:0] col;
    logic [COLW-1:0] mask;
    logic [NL:0]     tap;
    logic            eol;
    bit              chk_eol;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  exp_t tmp_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Raster expectation: pixel p of a frame whose pixel values are base+p.
  function automatic exp_t mk(input int base, input int p, input int len);
    exp_t e;
    int r;
    int c;
    r = p / len;
    c = p % len;
    e.col = '0;
    e.mask = '0;
    e.tap = '0;
    for (int k = 0; k <= NL; k++) begin
      if (r >= k) begin
        e.col[k*DW +: DW]  = DW'(base + p - k * len);
        e.mask[k*DW +: DW] = '1;
        e.tap[k]           = 1'b1;
      end
    end
    e.eol = (c == len - 1);
    e.chk_eol = 1'b1;
    return e;
  endfunction

  task automatic px(input bit sof, input int val, input int len);
    in_valid = 1'b1;
    in_sof   = sof;
    data_in  = DW'(val);
    line_len = CW'(len);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_valid: got out_valid=1, expected no column (t=%0t)", $time);
      end else begin
        mon_e = sb.pop_front();
        chk("col", 64'(out_col & mon_e.mask), 64'(mon_e.col));
        chk("tap_ok", 64'(out_tap_ok), 64'(mon_e.tap));
        if (mon_e.chk_eol) begin
          chk("eol", 64'(out_eol), 64'(mon_e.eol));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_col", 64'(out_col), 64'd0);
    chk("rst_tap", 64'(out_tap_ok), 64'd0);
    chk("rst_eol", 64'(out_eol), 64'd0);
    chk("rst_cfg_err", 64'(cfg_err), 64'd0);
    rst = 1'b0;

    // Continuous frame, len=4, values 0..11
    for (int p = 0; p < 12; p++) begin
      sb.push_back(mk(0, p, 4));
      px(p == 0, p, 4);
    end
    idle(2);

    // Same frame with a gap after every pixel
    for (int p = 0; p < 12; p++) begin
      sb.push_back(mk(0, p, 4));
      px(p == 0, p, 4);
      chk("lat_valid", 64'(out_valid), 64'd1);
      idle(1);
      chk("gap_valid", 64'(out_valid), 64'd0);
    end
    idle(2);

    // Reset during row 1, with a pixel presented in the reset cycle
    for (int p = 0; p < 6; p++) begin
      sb.push_back(mk(40, p, 4));
      px(p == 0, 40 + p, 4);
    end
    rst      = 1'b1;
    in_valid = 1'b1;
    data_in  = 8'd99;
    @(posedge clk);
    #1;
    chk("rst_mid_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_tap", 64'(out_tap_ok), 64'd0);
    rst      = 1'b0;
    in_valid = 1'b0;

    // Pixels without sof after reset are dropped
    for (int i = 0; i < 5; i++) begin
      px(1'b0, 200 + i, 4);
    end
    chk("drop_valid", 64'(out_valid), 64'd0);
    for (int p = 0; p < 8; p++) begin
      sb.push_back(mk(100, p, 4));
      px(p == 0, 100 + p, 4);
    end
    idle(1);

    // Mid-frame sof at row 1 col 2, re-latching len=3
    for (int p = 0; p < 6; p++) begin
      sb.push_back(mk(20, p, 4));
      px(p == 0, 20 + p, 4);
    end
    for (int p = 0; p < 9; p++) begin
      sb.push_back(mk(60, p, 3));
      px(p == 0, 60 + p, 3);
    end
    idle(1);

    // Illegal line length 1: data unspecified, tap validity still defined
    tmp_e = mk(0, 0, 4);
    tmp_e.mask = '0;
    tmp_e.chk_eol = 1'b0;
    sb.push_back(tmp_e);
    px(1'b1, 7, 1);
    chk("cfg_err_len1", 64'(cfg_err), 64'd1);
    sb.push_back(tmp_e);
    px(1'b0, 8, 1);
    chk("cfg_err_sticky", 64'(cfg_err), 64'd1);

    // Legal sof with len=8 clears the error
    for (int p = 0; p < 9; p++) begin
      sb.push_back(mk(150, p, 8));
      px(p == 0, 150 + p, 8);
      if (p == 0) begin
        chk("cfg_err_clear", 64'(cfg_err), 64'd0);
      end
    end

    // Length above MAX_WIDTH also flags, next legal sof clears
    sb.push_back(tmp_e);
    px(1'b1, 5, 9000);
    chk("cfg_err_big", 64'(cfg_err), 64'd1);
    sb.push_back(mk(6, 0, 8));
    px(1'b1, 6, 8);
    chk("cfg_err_clear2", 64'(cfg_err), 64'd0);

    idle(3);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
